// File: rtl/icdf_interp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icdf_interp_pipe : 3-stage inverse-CDF with a loadable half table,         |
// |                    odd symmetry and linear interpolation.                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module icdf_interp_pipe #(
  parameter int IN_W   = 32,
  parameter int ADDR_W = 6,
  parameter int FRAC_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   cdf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  icdf,
  input  logic              cfg_we,
  input  logic [ADDR_W:0]   cfg_addr,
  input  logic [OUT_W-2:0]  cfg_data
);

  localparam int              c_DEPTH    = 1 << ADDR_W;
  localparam int              c_IDX_W    = ADDR_W + FRAC_W;
  localparam int              c_PROD_W   = OUT_W - 1 + FRAC_W;
  localparam logic [ADDR_W:0] c_MAX_ADDR = (ADDR_W + 1)'(c_DEPTH);

  logic [OUT_W-2:0] r_table [c_DEPTH+1];

  logic               w_en;
  logic [c_IDX_W-1:0] w_field;
  logic [c_IDX_W-1:0] w_x;
  logic [ADDR_W:0]    w_k;
  logic [ADDR_W:0]    w_k_next;
  logic [FRAC_W-1:0]  w_f;

  logic               r_s1_valid;
  logic               r_s1_s;
  logic [OUT_W-2:0]   r_s1_hi;
  logic [OUT_W-2:0]   r_s1_lo;
  logic [FRAC_W-1:0]  r_s1_f;

  logic [OUT_W-1:0]   w_diff;
  logic [OUT_W-2:0]   w_d;
  logic [c_PROD_W-1:0] w_prod;

  logic               r_s2_valid;
  logic               r_s2_s;
  logic [OUT_W-2:0]   r_s2_t;
  logic [c_PROD_W-1:0] r_s2_prod;

  logic [OUT_W-2:0]   w_scaled;
  logic [OUT_W-2:0]   w_m;
  logic [OUT_W-1:0]   w_mag;
  logic [OUT_W-1:0]   w_icdf;

  logic               r_s3_valid;
  logic [OUT_W-1:0]   r_icdf;

  // Whole pipeline advances in lockstep; a stalled output freezes every stage.
  assign w_en      = !r_s3_valid || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_s3_valid;
  assign icdf      = r_icdf;

  // Upper half mirrors onto the lower half by complementing the fraction bits.
  assign w_field  = cdf[IN_W-2 -: c_IDX_W];
  assign w_x      = cdf[IN_W-1] ? ~w_field : w_field;
  assign w_k      = {1'b0, w_x[c_IDX_W-1 -: ADDR_W]};
  assign w_k_next = w_k + (ADDR_W + 1)'(1);
  assign w_f      = w_x[FRAC_W-1:0];

  if (IN_W - 1 > c_IDX_W) begin : g_lsbs
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^cdf[IN_W-2-c_IDX_W:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= c_DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (cfg_we && (cfg_addr <= c_MAX_ADDR)) begin
      r_table[cfg_addr] <= cfg_data;
    end
  end

  // A rising table segment would give a negative slope; treat it as flat.
  assign w_diff = {1'b0, r_s1_hi} - {1'b0, r_s1_lo};
  assign w_d    = w_diff[OUT_W-1] ? '0 : w_diff[OUT_W-2:0];
  assign w_prod = c_PROD_W'(w_d) * c_PROD_W'(r_s1_f);

  assign w_scaled = (OUT_W - 1)'(r_s2_prod >> FRAC_W);
  assign w_m      = r_s2_t - w_scaled;
  assign w_mag    = {1'b0, w_m};
  assign w_icdf   = r_s2_s ? w_mag : ('0 - w_mag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_s     <= 1'b0;
      r_s1_hi    <= '0;
      r_s1_lo    <= '0;
      r_s1_f     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_s     <= 1'b0;
      r_s2_t     <= '0;
      r_s2_prod  <= '0;
      r_s3_valid <= 1'b0;
      r_icdf     <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_s     <= cdf[IN_W-1];
      r_s1_hi    <= r_table[w_k];
      r_s1_lo    <= r_table[w_k_next];
      r_s1_f     <= w_f;
      r_s2_valid <= r_s1_valid;
      r_s2_s     <= r_s1_s;
      r_s2_t     <= r_s1_hi;
      r_s2_prod  <= w_prod;
      r_s3_valid <= r_s2_valid;
      r_icdf     <= w_icdf;
    end
  end

endmodule
`default_nettype wire
